// File: rtl/conv3x3_frame_sequencer_if.sv
// rtl/conv3x3_frame_sequencer_if.sv - RAM read, MAC tap and output pixel bundle for the 3x3 frame sequencer
interface conv3x3_frame_sequencer_if #(
  parameter int ADDRW = 14,
  parameter int ACCW  = 20,
  parameter int RW    = 7,
  parameter int CW    = 7
);
  logic                   mem_en;
  logic [ADDRW-1:0]       mem_addr;
  logic                   tap_en;
  logic [3:0]             tap_idx;
  logic                   acc_clr;
  logic signed [ACCW-1:0] acc_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_pix;
  logic [RW-1:0]          out_row;
  logic [CW-1:0]          out_col;
  logic                   out_last;

  modport master (
    output mem_en, mem_addr, tap_en, tap_idx, acc_clr,
    output out_valid, out_pix, out_row, out_col, out_last,
    input  acc_in, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, tap_en, tap_idx, acc_clr,
    input  out_valid, out_pix, out_row, out_col, out_last,
    output acc_in, out_ready
  );
endinterface

// File: rtl/conv3x3_frame_sequencer.sv
// rtl/conv3x3_frame_sequencer.sv - raster sequencer driving a shared 3x3 MAC over one frame
module conv3x3_frame_sequencer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int ADDRW  = 14,
  parameter int ACCW   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  conv3x3_frame_sequencer_if.master bus
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [RW-1:0]    ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(WIDTH - 1);
  localparam logic [ADDRW-1:0] W_A      = ADDRW'(WIDTH);
  localparam logic [ADDRW-1:0] W2_A     = ADDRW'(2 * WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT1, S_WAIT2, S_OUT, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [ADDRW-1:0] row_base_q, row_base_d;  // row_q * WIDTH, kept incrementally
  logic [ADDRW-1:0] base_q, base_d;          // top-left address of the 3x3 window
  logic [3:0]       k_q, k_d;
  logic [7:0]       pix_q, pix_d;
  logic             tap_en_q, tap_en_d;
  logic [3:0]       tap_idx_q, tap_idx_d;
  logic             acc_clr_q, acc_clr_d;

  logic             is_border;
  logic             at_last;
  logic [ADDRW-1:0] col_ext;
  logic [ACCW-1:0]  acc_raw;
  logic [ACCW-1:0]  acc_mag;
  logic [7:0]       acc_sat;

  // Window offsets are constants; the per-tap address is a single add.
  function automatic logic [ADDRW-1:0] tap_off(input logic [3:0] k);
    case (k)
      4'd0:    tap_off = ADDRW'(0);
      4'd1:    tap_off = ADDRW'(1);
      4'd2:    tap_off = ADDRW'(2);
      4'd3:    tap_off = W_A;
      4'd4:    tap_off = W_A + ADDRW'(1);
      4'd5:    tap_off = W_A + ADDRW'(2);
      4'd6:    tap_off = W2_A;
      4'd7:    tap_off = W2_A + ADDRW'(1);
      default: tap_off = W2_A + ADDRW'(2);
    endcase
  endfunction

  assign is_border = (row_q == '0) || (row_q == ROW_LAST) ||
                     (col_q == '0) || (col_q == COL_LAST);
  assign at_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign col_ext   = ADDRW'(col_q);

  // Magnitude with two's-complement negation; the most-negative value keeps its MSB and saturates.
  assign acc_raw = bus.acc_in;
  assign acc_mag = acc_raw[ACCW-1] ? (~acc_raw + ACCW'(1)) : acc_raw;
  assign acc_sat = (|acc_mag[ACCW-1:8]) ? 8'hFF : acc_mag[7:0];

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      base_q     <= '0;
      k_q        <= '0;
      pix_q      <= '0;
      tap_en_q   <= 1'b0;
      tap_idx_q  <= '0;
      acc_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      base_q     <= base_d;
      k_q        <= k_d;
      pix_q      <= pix_d;
      tap_en_q   <= tap_en_d;
      tap_idx_q  <= tap_idx_d;
      acc_clr_q  <= acc_clr_d;
    end
  end

  // Next-state and next-datapath logic; tap strobes are one-cycle copies of the RAM read so they line up with read data.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    base_d     = base_q;
    k_d        = k_q;
    pix_d      = pix_q;
    tap_en_d   = (state_q == S_ISSUE);
    tap_idx_d  = (state_q == S_ISSUE) ? k_q : 4'd0;
    acc_clr_d  = (state_q == S_ISSUE) && (k_q == 4'd0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d      = '0;
          col_d      = '0;
          row_base_d = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (is_border) begin
          pix_d   = 8'd0;
          state_d = S_OUT;
        end else begin
          base_d  = row_base_q - W_A + col_ext - ADDRW'(1);
          k_d     = 4'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (k_q == 4'd8) begin
          state_d = S_WAIT1;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_WAIT1: state_d = S_WAIT2;
      S_WAIT2: begin
        pix_d   = acc_sat;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (at_last) begin
            state_d = S_FIN;
          end else if (col_q == COL_LAST) begin
            col_d      = '0;
            row_d      = row_q + RW'(1);
            row_base_d = row_base_q + W_A;
            state_d    = S_SCAN;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_SCAN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so reset clears them immediately.
  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_FIN);
    done          = (state_q == S_FIN);
    bus.mem_en    = (state_q == S_ISSUE);
    bus.mem_addr  = (state_q == S_ISSUE) ? (base_q + tap_off(k_q)) : '0;
    bus.tap_en    = tap_en_q;
    bus.tap_idx   = tap_idx_q;
    bus.acc_clr   = acc_clr_q;
    bus.out_valid = (state_q == S_OUT);
    bus.out_pix   = pix_q;
    bus.out_row   = row_q;
    bus.out_col   = col_q;
    bus.out_last  = (state_q == S_OUT) && at_last;
  end
endmodule
